// File: rtl/uart_rx.sv
// 8N1 serial receiver, mid-bit sampling at CLKS_PER_BIT clocks per bit.
// Define UART_RX_SYNC_EN to pass i_rxd through a two-flop synchronizer.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rxd,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    // state | meaning
    // IDLE  | line idle, waiting for a low level on rxd_s
    // START | timing to mid start bit to reject glitches
    // DATA  | sampling 8 data bits LSB first at mid-bit
    // STOP  | timing to mid stop bit, then present byte or flag error
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);

    logic          rxd_s;
    state_t        state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync;

    // Flops reset to the idle level so reset never looks like a start bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) sync <= 2'b11;
        else         sync <= {sync[0], i_rxd};
    end
    assign rxd_s = sync[1];
`else
    assign rxd_s = i_rxd;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state   <= START;
                        clk_cnt <= '0;
                        o_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_TC) begin
                        clk_cnt <= '0;
                        if (!rxd_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == FULL_TC) begin
                        clk_cnt        <= '0;
                        shreg[bit_idx] <= rxd_s;
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop gives half a bit of margin for the next start edge.
                    if (clk_cnt == FULL_TC) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        o_busy  <= 1'b0;
                        if (rxd_s) begin
                            o_data  <= shreg;
                            o_valid <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and random frames against a
// timing/byte reference model built from the frame rules.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_rxd;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int         exp_v_cyc[$];
    logic [7:0] exp_v_data[$];
    int         exp_e_cyc[$];
    int         obs_v_cyc[$];
    logic [7:0] obs_v_data[$];
    int         obs_e_cyc[$];
    logic [7:0] exp_data;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_rxd      (i_rxd),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Pulse recorder: stamps every cycle an output pulse is visible.
    always @(posedge i_clk) begin
        #1;
        if (o_valid) begin
            obs_v_cyc.push_back(cyc);
            obs_v_data.push_back(o_data);
        end
        if (o_frame_err) obs_e_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drives one frame; every event is referenced to t0, the first edge where
    // the receiver sees the start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        int t0, stop_edge;
        bits      = {stop, b, 1'b0};
        t0        = cyc + 1 + LAT;
        stop_edge = t0 + HALF + 9 * CPB;
        for (int i = 0; i < 10; i++) begin
            i_rxd = bits[i];
            for (int j = 0; j < CPB; j++) begin
                tick();
                if (cyc == t0)            chk("busy_rise", o_busy, 1);
                if (cyc == stop_edge - 1) chk("busy_before_stop", o_busy, 1);
                if (cyc == stop_edge)     chk("busy_fall", o_busy, 0);
            end
        end
        i_rxd = 1'b1;
        if (stop) begin
            exp_v_cyc.push_back(stop_edge);
            exp_v_data.push_back(b);
            exp_data = b;
        end else begin
            exp_e_cyc.push_back(stop_edge);
        end
    endtask

    task automatic check_pulses(input string tag);
        chk({tag, "_valid_count"}, obs_v_cyc.size(), exp_v_cyc.size());
        for (int i = 0; i < exp_v_cyc.size() && i < obs_v_cyc.size(); i++) begin
            chk({tag, "_valid_cycle"}, obs_v_cyc[i], exp_v_cyc[i]);
            chk({tag, "_valid_data"}, obs_v_data[i], exp_v_data[i]);
        end
        chk({tag, "_err_count"}, obs_e_cyc.size(), exp_e_cyc.size());
        for (int i = 0; i < exp_e_cyc.size() && i < obs_e_cyc.size(); i++)
            chk({tag, "_err_cycle"}, obs_e_cyc[i], exp_e_cyc[i]);
        chk({tag, "_data_held"}, o_data, exp_data);
        exp_v_cyc.delete();
        exp_v_data.delete();
        exp_e_cyc.delete();
        obs_v_cyc.delete();
        obs_v_data.delete();
        obs_e_cyc.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        int         gap, t0;

        i_reset  = 1'b1;
        i_rxd    = 1'b1;
        exp_data = 8'h00;
        repeat (3) tick();
        chk("reset_data", o_data, 0);
        chk("reset_valid", o_valid, 0);
        chk("reset_err", o_frame_err, 0);
        chk("reset_busy", o_busy, 0);
        i_reset = 1'b0;
        repeat (4) tick();

        send_frame(8'hA5, 1'b1);
        repeat (CPB) tick();
        check_pulses("good_a5");

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (CPB) tick();
        check_pulses("b2b_extremes");

        send_frame(8'h3C, 1'b0);
        repeat (2 * CPB) tick();
        check_pulses("frame_err");

        // Four-cycle low glitch must be rejected at the mid-start check.
        t0    = cyc + 1 + LAT;
        i_rxd = 1'b0;
        repeat (4) tick();
        i_rxd = 1'b1;
        while (cyc < t0 + HALF - 1) tick();
        chk("glitch_busy_before", o_busy, 1);
        tick();
        chk("glitch_idle", o_busy, 0);
        repeat (CPB) tick();
        send_frame(8'h5A, 1'b1);
        repeat (CPB) tick();
        check_pulses("glitch_then_5a");

        // Reset in the middle of data bit 3 discards the frame.
        b     = 8'hC3;
        i_rxd = 1'b0;
        repeat (CPB) tick();
        for (int k = 0; k < 3; k++) begin
            i_rxd = b[k];
            repeat (CPB) tick();
        end
        i_rxd = b[3];
        repeat (HALF) tick();
        chk("midframe_busy", o_busy, 1);
        i_reset = 1'b1;
        i_rxd   = 1'b1;
        tick();
        i_reset = 1'b0;
        exp_data = 8'h00;
        chk("midrst_data", o_data, 0);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_err", o_frame_err, 0);
        chk("midrst_busy", o_busy, 0);
        repeat (2 * CPB) tick();
        check_pulses("midrst_none");
        send_frame(8'h81, 1'b1);
        repeat (CPB) tick();
        check_pulses("after_rst_81");

        for (int n = 0; n < 12; n++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            gap  = stop ? $urandom_range(0, 20) : CPB + $urandom_range(0, 10);
            send_frame(b, stop);
            repeat (gap) tick();
        end
        repeat (2 * CPB) tick();
        check_pulses("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
